// File: rtl/crossbar_sched_pkg.sv
// Shared types and defaults for the crossbar output-port scheduler.
// ID_W is fixed here, so NUM_PROC on any instance must not exceed 2**ID_W.
package crossbar_sched_pkg;

    localparam int NUM_PROC_DEF    = 4;
    localparam int ID_W            = (NUM_PROC_DEF > 1) ? $clog2(NUM_PROC_DEF) : 1;
    localparam int XFER_CYCLES_DEF = 2;
    localparam int ADDR_W          = 16;

    typedef struct packed {
        logic [ID_W-1:0]   dest;
        logic [ID_W-1:0]   src;
        logic [ADDR_W-1:0] memory_address;
    } pkt_t;

    // Round-robin successor of cur within 0..n-1.
    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] cur, input int n);
        int nxt;
        nxt = int'(cur) + 1;
        return (nxt >= n) ? '0 : ID_W'(nxt);
    endfunction

endpackage

// File: rtl/crossbar_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr,
// wrapping modulo N. gnt is one-hot or all zero.
module rr_arbiter
    import crossbar_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    int            scan;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        scan    = 0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            scan = (int'(ptr) + k) % N;
            idx  = IW'(scan);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/crossbar_sched.sv
// Per-output round-robin scheduler: accepts one packet per output, then holds
// the output busy for XFER_CYCLES cycles while driving packet and crossbar select.
module crossbar_sched
    import crossbar_sched_pkg::*;
#(
    parameter int NUM_PROC    = NUM_PROC_DEF,
    parameter int XFER_CYCLES = XFER_CYCLES_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PROC-1:0]            req_valid,
    input  pkt_t [NUM_PROC-1:0]            req_pkt,
    output logic [NUM_PROC-1:0]            req_ready,
    output logic [NUM_PROC-1:0]            out_valid,
    output pkt_t [NUM_PROC-1:0]            out_pkt,
    output logic [NUM_PROC-1:0][ID_W-1:0]  out_sel,
    output logic                           bad_dest
);

    logic [3:0]          cnt      [NUM_PROC];
    logic [ID_W-1:0]     ptr      [NUM_PROC];
    logic [NUM_PROC-1:0] req_set  [NUM_PROC];
    logic [NUM_PROC-1:0] gnt      [NUM_PROC];
    logic [ID_W-1:0]     gnt_idx  [NUM_PROC];
    logic [NUM_PROC-1:0] eligible;
    logic [NUM_PROC-1:0] accept;
    logic [NUM_PROC-1:0] rdy;
    logic [NUM_PROC-1:0] bad_req;

    always_comb begin
        for (int o = 0; o < NUM_PROC; o++) begin
            for (int s = 0; s < NUM_PROC; s++) begin
                req_set[o][s] = req_valid[s] && (int'(req_pkt[s].dest) == o);
            end
        end
    end

    for (genvar o = 0; o < NUM_PROC; o++) begin : g_out
        rr_arbiter #(.N(NUM_PROC)) u_arb (
            .req     (req_set[o]),
            .ptr     (ptr[o]),
            .gnt     (gnt[o]),
            .gnt_idx (gnt_idx[o])
        );
        // cnt == 1 is the last busy cycle, so a new accept there leaves no bubble.
        assign eligible[o]  = (cnt[o] <= 4'd1);
        assign accept[o]    = eligible[o] && (|gnt[o]);
        assign out_valid[o] = (cnt[o] != 4'd0);
    end

    always_comb begin
        rdy     = '0;
        bad_req = '0;
        for (int o = 0; o < NUM_PROC; o++) begin
            rdy = rdy | (gnt[o] & {NUM_PROC{eligible[o]}});
        end
        for (int s = 0; s < NUM_PROC; s++) begin
            bad_req[s] = req_valid[s] && (int'(req_pkt[s].dest) >= NUM_PROC);
        end
        req_ready = rst ? '0 : rdy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_PROC; o++) begin
                cnt[o]     <= '0;
                ptr[o]     <= '0;
                out_pkt[o] <= '0;
                out_sel[o] <= '0;
            end
            bad_dest <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PROC; o++) begin
                if (accept[o]) begin
                    cnt[o]     <= 4'(XFER_CYCLES);
                    out_pkt[o] <= req_pkt[gnt_idx[o]];
                    out_sel[o] <= gnt_idx[o];
                    ptr[o]     <= next_idx(gnt_idx[o], NUM_PROC);
                end else if (cnt[o] != 4'd0) begin
                    cnt[o] <= cnt[o] - 4'd1;
                end
            end
            if (|bad_req) begin
                bad_dest <= 1'b1;
            end
        end
    end

endmodule
